// File: rtl/vga_pkg.sv
// Shared definitions for the VGA gain controller: default sizes, FSM states, step decode.
package vga_pkg;

  localparam int unsigned NCH_DEF = 8;
  localparam int unsigned GW_DEF  = 6;
  localparam int unsigned CW      = $clog2(NCH_DEF);
  localparam int unsigned FRAME_W = CW + GW_DEF;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  // step code 0..3 selects an increment of 1, 2, 4 or 8
  function automatic logic [3:0] stepInc(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Rising-edge detector for request levels; VGA_GAIN_SYNC_EN adds a 2-flop synchronizer
// in front of the registered edge pulse.
module vga_edge_det #(
  parameter int unsigned N = 8
) (
  input  logic         clk_1M,
  input  logic         rst,
  input  logic [N-1:0] level,
  output logic [N-1:0] rise
);

  logic [N-1:0] lvl;
  logic [N-1:0] prev;

`ifdef VGA_GAIN_SYNC_EN
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;

  always_ff @(posedge clk_1M) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= level;
      sync2 <= sync1;
    end
  end

  assign lvl = sync2;
`else
  assign lvl = level;
`endif

  always_ff @(posedge clk_1M) begin
    if (rst) begin
      prev <= '0;
      rise <= '0;
    end else begin
      prev <= lvl;
      rise <= lvl & ~prev;
    end
  end

endmodule

// File: rtl/vga_gain_ctrl.sv
// Per-channel saturating gain codes with round-robin serial write-out of changed channels.
// Define VGA_GAIN_SYNC_EN to synchronize the asynchronous up/down request pins.
module vga_gain_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned NCH       = NCH_DEF,
  parameter int unsigned GW        = GW_DEF,
  parameter int unsigned GAIN_MAX  = 63,
  parameter int unsigned GAIN_INIT = 32
) (
  input  logic              clk_1M,
  input  logic              rst,
  input  logic [NCH-1:0]    up,
  input  logic [NCH-1:0]    down,
  input  logic [1:0]        step,
  output logic [NCH*GW-1:0] gain,
  output logic              busy,
  output logic              vga_sclk,
  output logic              vga_sdata,
  output logic              vga_le
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned FRW = CHW + GW;
  localparam int unsigned BCW = $clog2(FRW);
  localparam logic [GW:0]   GMAX_X = (GW + 1)'(GAIN_MAX);
  localparam logic [GW-1:0] GMAX_G = GW'(GAIN_MAX);

  logic [NCH-1:0] upRise;
  logic [NCH-1:0] downRise;

  vga_edge_det #(.N(NCH)) upDet (
    .clk_1M (clk_1M),
    .rst    (rst),
    .level  (up),
    .rise   (upRise)
  );

  vga_edge_det #(.N(NCH)) downDet (
    .clk_1M (clk_1M),
    .rst    (rst),
    .level  (down),
    .rise   (downRise)
  );

  logic [GW-1:0]  gainQ [NCH];
  logic [GW-1:0]  gainD [NCH];
  logic [NCH-1:0] dirty;
  logic [NCH-1:0] dirtyD;
  logic [NCH-1:0] dirtySet;
  logic [GW:0]    inc;

  state_t          state;
  logic [CHW-1:0]  rrPtr;
  logic [CHW-1:0]  chSel;
  logic [FRW-1:0]  frameSr;
  logic [FRW-1:0]  frameNext;
  logic [BCW-1:0]  bitCnt;
  logic            phase;
  logic            pickFound;
  logic [CHW-1:0]  pickCh;

  // Arithmetic is one bit wider than the code so saturation never sees a wrapped value.
  always_comb begin
    inc = (GW + 1)'(stepInc(step));
    for (int i = 0; i < NCH; i++) begin
      gainD[i] = gainQ[i];
      if (upRise[i] && !downRise[i]) begin
        gainD[i] = (({1'b0, gainQ[i]} + inc) > GMAX_X) ? GMAX_G
                                                        : GW'({1'b0, gainQ[i]} + inc);
      end else if (downRise[i] && !upRise[i]) begin
        gainD[i] = ({1'b0, gainQ[i]} < inc) ? '0 : GW'({1'b0, gainQ[i]} - inc);
      end
      dirtySet[i] = (gainD[i] != gainQ[i]);
    end
  end

  // A same-cycle update of the channel being loaded must survive the clear.
  always_comb begin
    dirtyD = dirty;
    if (state == LOAD) begin
      dirtyD[chSel] = 1'b0;
    end
    dirtyD = dirtyD | dirtySet;
  end

  always_ff @(posedge clk_1M) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        gainQ[i] <= GW'(GAIN_INIT);
      end
      dirty <= '1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        gainQ[i] <= gainD[i];
      end
      dirty <= dirtyD;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      gain[i*GW +: GW] = gainQ[i];
    end
  end

  // Lowest dirty channel at or above rrPtr, wrapping.
  always_comb begin
    int unsigned idx;
    logic [CHW-1:0] idxC;
    idx       = 0;
    idxC      = '0;
    pickFound = 1'b0;
    pickCh    = '0;
    for (int k = 0; k < NCH; k++) begin
      idx  = (int'(rrPtr) + k) % NCH;
      idxC = CHW'(idx);
      if (!pickFound && dirty[idxC]) begin
        pickFound = 1'b1;
        pickCh    = idxC;
      end
    end
  end

  assign frameNext = {chSel, gainQ[chSel]};

  always_ff @(posedge clk_1M) begin
    if (rst) begin
      state     <= IDLE;
      rrPtr     <= '0;
      chSel     <= '0;
      frameSr   <= '0;
      bitCnt    <= '0;
      phase     <= 1'b0;
      busy      <= 1'b0;
      vga_sclk  <= 1'b0;
      vga_sdata <= 1'b0;
      vga_le    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pickFound) begin
            chSel <= pickCh;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          frameSr   <= frameNext;
          vga_sdata <= frameNext[FRW-1];
          vga_sclk  <= 1'b0;
          rrPtr     <= (chSel == CHW'(NCH - 1)) ? '0 : chSel + 1'b1;
          bitCnt    <= '0;
          phase     <= 1'b0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (!phase) begin
            phase    <= 1'b1;
            vga_sclk <= 1'b1;
          end else begin
            phase    <= 1'b0;
            vga_sclk <= 1'b0;
            if (bitCnt == BCW'(FRW - 1)) begin
              vga_sdata <= 1'b0;
              vga_le    <= 1'b1;
              state     <= LATCH;
            end else begin
              bitCnt    <= bitCnt + 1'b1;
              frameSr   <= frameSr << 1;
              vga_sdata <= frameSr[FRW-2];
            end
          end
        end
        LATCH: begin
          vga_le <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_gain_ctrl.sv
// Self-checking bench for vga_gain_ctrl: cycle model of gains/dirty/frames plus literal checks.
`timescale 1ns/1ps
module tb_vga_gain_ctrl;

  localparam int NCH   = 8;
  localparam int GW    = 6;
  localparam int GMAX  = 63;
  localparam int GINIT = 32;
  localparam int FLEN  = 20;
`ifdef VGA_GAIN_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk_1M = 1'b0;
  logic          rst    = 1'b0;
  logic [7:0]    up     = '0;
  logic [7:0]    down   = '0;
  logic [1:0]    step   = '0;
  logic [47:0]   gain;
  logic          busy;
  logic          vga_sclk;
  logic          vga_sdata;
  logic          vga_le;

  vga_gain_ctrl #(
    .NCH       (NCH),
    .GW        (GW),
    .GAIN_MAX  (GMAX),
    .GAIN_INIT (GINIT)
  ) dut (
    .clk_1M    (clk_1M),
    .rst       (rst),
    .up        (up),
    .down      (down),
    .step      (step),
    .gain      (gain),
    .busy      (busy),
    .vga_sclk  (vga_sclk),
    .vga_sdata (vga_sdata),
    .vga_le    (vga_le)
  );

  always #500 clk_1M = ~clk_1M;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: gains, dirty set, round-robin pointer and the frame position counter.
  int   mGain [NCH];
  bit   mDirty[NCH];
  int   mRr;
  int   mCh;
  int   mFcyc = -1;
  int   mFrame;
  int   mNg;
  int   mInc;
  bit   mValid = 1'b0;
  logic [7:0] hUp[5];
  logic [7:0] hDn[5];
  bit   upR;
  bit   dnR;

  always @(posedge clk_1M) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        mGain[i]  = GINIT;
        mDirty[i] = 1'b1;
      end
      mRr    = 0;
      mCh    = 0;
      mFcyc  = -1;
      mFrame = 0;
      for (int j = 0; j < 5; j++) begin
        hUp[j] = '0;
        hDn[j] = '0;
      end
      mValid = 1'b1;
    end else begin
      if (mFcyc < 0) begin
        for (int k = 0; k < NCH; k++) begin
          if (mFcyc < 0 && mDirty[(mRr + k) % NCH]) begin
            mCh   = (mRr + k) % NCH;
            mFcyc = 0;
          end
        end
      end else if (mFcyc == 0) begin
        mFrame        = mCh * 64 + mGain[mCh];
        mDirty[mCh]   = 1'b0;
        mRr           = (mCh + 1) % NCH;
        mFcyc         = 1;
      end else if (mFcyc < FLEN - 1) begin
        mFcyc++;
      end else begin
        mFcyc = -1;
      end
      mInc = 1 << step;
      for (int i = 0; i < NCH; i++) begin
        upR = hUp[LAT-2][i] && !hUp[LAT-1][i];
        dnR = hDn[LAT-2][i] && !hDn[LAT-1][i];
        mNg = mGain[i];
        if (upR && !dnR) mNg = (mGain[i] + mInc > GMAX) ? GMAX : mGain[i] + mInc;
        else if (dnR && !upR) mNg = (mGain[i] - mInc < 0) ? 0 : mGain[i] - mInc;
        if (mNg != mGain[i]) begin
          mGain[i]  = mNg;
          mDirty[i] = 1'b1;
        end
      end
      for (int j = 4; j > 0; j--) begin
        hUp[j] = hUp[j-1];
        hDn[j] = hDn[j-1];
      end
      hUp[0] = up;
      hDn[0] = down;
    end
  end

  // Per-cycle compare of every output against the model.
  logic [47:0] eGain;
  int          t;
  always @(negedge clk_1M) begin
    if (mValid) begin
      for (int i = 0; i < NCH; i++) eGain[i*GW +: GW] = 6'(mGain[i]);
      t = mFcyc;
      check("gain", 64'(gain), 64'(eGain));
      check("busy", 64'(busy), 64'(t >= 0));
      check("sclk", 64'(vga_sclk), 64'(t >= 1 && t <= 18 && ((t - 1) % 2 == 1)));
      check("sdata", 64'(vga_sdata),
            64'((t >= 1 && t <= 18) ? ((mFrame >> (8 - (t - 1) / 2)) & 1) : 0));
      check("le", 64'(vga_le), 64'(t == FLEN - 1));
    end
  end

  // Decode frames off the serial pins.
  logic [8:0] acc = '0;
  int         frames[$];
  always @(negedge clk_1M) begin
    if (vga_sclk === 1'b1) acc = {acc[7:0], vga_sdata};
    if (vga_le === 1'b1) frames.push_back(int'(acc));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_1M);
  endtask

  task automatic pulse(input logic [7:0] um, input logic [7:0] dm);
    up   = up | um;
    down = down | dm;
    cyc(3);
    up   = up & ~um;
    down = down & ~dm;
    cyc(3);
  endtask

  task automatic chkFrame(input string name, input int idx, input int exp);
    if (idx < frames.size()) check(name, 64'(frames[idx]), 64'(exp));
    else check({name, " missing"}, 64'(frames.size()), 64'(idx + 1));
  endtask

  int base;
  int d3[5];
  bit hit;

  initial begin
    d3 = '{24, 16, 8, 0, 0};
    rst = 1'b1;
    cyc(3);
    check("reset busy", 64'(busy), 64'd0);
    check("reset le", 64'(vga_le), 64'd0);
    check("reset gain", 64'(gain), 64'h820820820820);
    rst = 1'b0;

    // 1: power-up rewrite of all channels
    cyc(8 * 21 + 10);
    check("t1 frame count", 64'(frames.size()), 64'd8);
    for (int i = 0; i < 8; i++) chkFrame("t1 frame", i, i * 64 + 32);
    check("t1 idle busy", 64'(busy), 64'd0);

    // 2: three step-2 ups on ch3
    base = frames.size();
    step = 2'd2;
    for (int i = 0; i < 3; i++) pulse(8'h08, 8'h00);
    cyc(60);
    check("t2 gain3", 64'(gain[18 +: 6]), 64'd44);
    check("t2 model gain3", 64'(mGain[3]), 64'd44);
    chkFrame("t2 first frame", base, 3 * 64 + 36);
    chkFrame("t2 last frame", base + 1, 9'b011_101100);

    // 3: step-3 saturation at both ends on ch5
    step = 2'd3;
    for (int i = 0; i < 5; i++) begin
      pulse(8'h00, 8'h20);
      check("t3 down gain5", 64'(gain[30 +: 6]), 64'(d3[i]));
    end
    for (int i = 0; i < 7; i++) pulse(8'h20, 8'h00);
    step = 2'd2;
    pulse(8'h20, 8'h00);
    check("t3 gain5 60", 64'(gain[30 +: 6]), 64'd60);
    step = 2'd3;
    pulse(8'h20, 8'h00);
    check("t3 gain5 sat", 64'(gain[30 +: 6]), 64'd63);
    check("t3 model sat", 64'(mGain[5]), 64'd63);
    cyc(80);

    // 4: simultaneous up/down on ch2, and an up already at the limit on ch5
    base = frames.size();
    pulse(8'h24, 8'h04);
    cyc(40);
    check("t4 no frame", 64'(frames.size()), 64'(base));
    check("t4 gain2", 64'(gain[12 +: 6]), 64'd32);
    check("t4 gain5", 64'(gain[30 +: 6]), 64'd63);

    // 5: round-robin wrap from rr_ptr=7 and reframe after a mid-frame update
    step = 2'd0;
    base = frames.size();
    pulse(8'h40, 8'h00);
    pulse(8'h42, 8'h00);
    cyc(14);
    pulse(8'h02, 8'h00);
    cyc(100);
    check("t5 frame count", 64'(frames.size()), 64'(base + 4));
    chkFrame("t5 ch6 a", base, 6 * 64 + 33);
    chkFrame("t5 ch1 a", base + 1, 1 * 64 + 33);
    chkFrame("t5 ch6 b", base + 2, 6 * 64 + 34);
    chkFrame("t5 ch1 b", base + 3, 1 * 64 + 34);

    // 6: reset in the middle of bit 4
    up = 8'h01;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk_1M);
      if (mFcyc == 9) hit = 1'b1;
    end
    check("t6 reached bit4", 64'(hit), 64'd1);
    check("t6 busy mid", 64'(busy), 64'd1);
    base = frames.size();
    rst = 1'b1;
    up  = 8'h00;
    @(negedge clk_1M);
    check("t6 rst busy", 64'(busy), 64'd0);
    check("t6 rst sclk", 64'(vga_sclk), 64'd0);
    check("t6 rst sdata", 64'(vga_sdata), 64'd0);
    check("t6 rst le", 64'(vga_le), 64'd0);
    cyc(2);
    rst = 1'b0;
    cyc(8 * 21 + 10);
    check("t6 frame count", 64'(frames.size()), 64'(base + 8));
    for (int i = 0; i < 8; i++) chkFrame("t6 frame", base + i, i * 64 + 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
